fetch_unit: RTL and testbench

- Instruction-fetch stage that produces the instruction word and branch-epoch tag consumed by the decode-stage instruction register (`instr_in`, `branch_in`, `branch_ref`, `sel_stall`).
- Owns the PC, issues word reads to instruction memory with a one-outstanding-request handshake, and buffers returned words in a small FIFO.
- Toggles the epoch bit on every branch redirect so in-flight wrong-path instructions are squashed to NOP downstream.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding-request handshake
// to instruction memory and feeds decode from a small FIFO tagged with the branch epoch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        sel_stall,
  output logic [31:0] instr_out,
  output logic        branch_out,
  output logic        branch_ref,
  output logic [31:0] pc_out
);

  // state   | meaning
  // S_FETCH | request pc when buffer has room and no redirect is pending
  // S_WAIT  | one request accepted, waiting for its read data

  localparam logic [31:0] NOP = 32'hE320_F000;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic            epoch;
  logic            discard;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     buf_instr [BUF_DEPTH];
  logic [31:0]     buf_pc    [BUF_DEPTH];
  logic            buf_epoch [BUF_DEPTH];

  logic fire, push, pop, empty;

  assign empty     = (count == '0);
  assign imem_req  = !rst && (state == S_FETCH) && (count < DEPTH_C) && !redirect_en;
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  assign push      = (state == S_WAIT) && imem_rvalid && !discard && !redirect_en;
  assign pop       = !empty && !sel_stall && !redirect_en;

  assign instr_out  = empty ? NOP   : buf_instr[rd_ptr];
  assign branch_out = empty ? epoch : buf_epoch[rd_ptr];
  assign pc_out     = empty ? pc    : buf_pc[rd_ptr];
  assign branch_ref = epoch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      req_pc  <= RESET_PC;
      epoch   <= 1'b0;
      discard <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (redirect_en) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      epoch  <= ~epoch;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // A response landing in the redirect cycle is the outstanding one; nothing left to squash.
      if (state == S_WAIT) begin
        if (imem_rvalid) begin
          state   <= S_FETCH;
          discard <= 1'b0;
        end else begin
          discard <= 1'b1;
        end
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
      if (push) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]    <= req_pc;
        buf_epoch[wr_ptr] <= epoch;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // The cycle right after reset may still see a response to a request issued before it.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
    (imem_rvalid && !$past(rst)) |-> (state == S_WAIT));
  a_count_bound: assert property (@(posedge clk) count <= DEPTH_C);
  a_addr_align: assert property (@(posedge clk) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for handshake, stall, redirect,
// wrap and reset corners, followed by a stalled streaming run against a small memory model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hE320_F000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        sel_stall;
  logic [31:0] instr_out;
  logic        branch_out;
  logic        branch_ref;
  logic [31:0] pc_out;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .sel_stall(sel_stall),
    .instr_out(instr_out), .branch_out(branch_out), .branch_ref(branch_ref), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, gnt, rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        req;
    logic [31:0] addr, instr;
    logic        bout, bref;
    logic [31:0] pcout;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] d(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic add(input logic r, input logic g, input logic v, input logic [31:0] rd,
                     input logic rr, input logic [31:0] rp, input logic s,
                     input logic q, input logic [31:0] a, input logic [31:0] i,
                     input logic bo, input logic br, input logic [31:0] p);
    vec_t t;
    t.rst = r; t.gnt = g; t.rvalid = v; t.rdata = rd; t.redir = rr; t.rpc = rp; t.stall = s;
    t.req = q; t.addr = a; t.instr = i; t.bout = bo; t.bref = br; t.pcout = p;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  int          got;

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_en = 1'b0; redirect_pc = '0; sel_stall = 1'b0;

    // rst gnt rv rdata redir rpc stall | req addr instr bout bref pc_out
    add(1,0,0,0,0,0,0,                 0,0,NOP,0,0,0);
    add(0,1,0,0,0,0,0,                 1,0,NOP,0,0,0);
    add(0,1,1,d(0),0,0,0,              0,4,NOP,0,0,4);
    add(0,1,0,0,0,0,0,                 1,4,d(0),0,0,0);
    add(0,1,1,d(4),0,0,0,              0,8,NOP,0,0,8);
    add(0,1,0,0,0,0,0,                 1,8,d(4),0,0,4);
    // six stalled cycles: buffer fills, request drops, output held
    add(0,1,1,d(8),0,0,1,              0,12,NOP,0,0,12);
    add(0,1,0,0,0,0,1,                 1,12,d(8),0,0,8);
    add(0,1,1,d(12),0,0,1,             0,16,d(8),0,0,8);
    add(0,1,0,0,0,0,1,                 0,16,d(8),0,0,8);
    add(0,1,0,0,0,0,1,                 0,16,d(8),0,0,8);
    add(0,1,0,0,0,0,1,                 0,16,d(8),0,0,8);
    add(0,1,0,0,0,0,0,                 0,16,d(8),0,0,8);
    add(0,1,0,0,0,0,0,                 1,16,d(12),0,0,12);
    // redirect while waiting: late response dropped, epoch flips
    add(0,1,0,0,1,32'h100,0,           0,20,NOP,0,0,20);
    add(0,1,1,d(16),0,0,0,             0,32'h100,NOP,1,1,32'h100);
    add(0,1,0,0,0,0,0,                 1,32'h100,NOP,1,1,32'h100);
    add(0,1,1,d(32'h100),0,0,0,        0,32'h104,NOP,1,1,32'h104);
    add(0,0,0,0,0,0,0,                 1,32'h104,d(32'h100),1,1,32'h100);
    add(0,1,0,0,0,0,0,                 1,32'h104,NOP,1,1,32'h104);
    // back-to-back redirects while waiting
    add(0,1,0,0,1,32'h200,0,           0,32'h108,NOP,1,1,32'h108);
    add(0,1,0,0,1,32'h300,0,           0,32'h200,NOP,0,0,32'h200);
    add(0,1,1,d(32'h104),0,0,0,        0,32'h300,NOP,1,1,32'h300);
    add(0,1,0,0,0,0,0,                 1,32'h300,NOP,1,1,32'h300);
    add(0,1,1,d(32'h300),0,0,0,        0,32'h304,NOP,1,1,32'h304);
    add(0,0,0,0,0,0,1,                 1,32'h304,d(32'h300),1,1,32'h300);
    add(0,1,0,0,0,0,1,                 1,32'h304,d(32'h300),1,1,32'h300);
    // redirect together with rvalid and stall
    add(0,1,1,d(32'h304),1,32'h400,1,  0,32'h308,d(32'h300),1,1,32'h300);
    add(0,0,0,0,0,0,1,                 1,32'h400,NOP,0,0,32'h400);
    // wrap from the top of the address space, low target bits ignored
    add(0,1,0,0,1,32'hFFFF_FFFF,0,     0,32'h400,NOP,0,0,32'h400);
    add(0,1,0,0,0,0,0,                 1,32'hFFFF_FFFC,NOP,1,1,32'hFFFF_FFFC);
    add(0,1,0,0,0,0,0,                 0,0,NOP,1,1,0);
    add(0,1,1,d(32'hFFFF_FFFC),0,0,0,  0,0,NOP,1,1,0);
    add(0,1,0,0,0,0,0,                 1,0,d(32'hFFFF_FFFC),1,1,32'hFFFF_FFFC);
    // reset while waiting, then a stray response
    add(1,1,0,0,0,0,0,                 0,4,NOP,1,1,4);
    add(0,0,1,32'hDEAD_BEEF,0,0,0,     1,0,NOP,0,0,0);
    add(0,0,0,0,0,0,0,                 1,0,NOP,0,0,0);
    add(0,1,0,0,0,0,0,                 1,0,NOP,0,0,0);
    add(0,1,1,d(0),0,0,0,              0,4,NOP,0,0,4);
    add(0,0,0,0,0,0,0,                 1,4,d(0),0,0,0);
    add(0,0,0,0,0,0,0,                 1,4,NOP,0,0,4);

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
      imem_rdata = vecs[i].rdata; redirect_en = vecs[i].redir;
      redirect_pc = vecs[i].rpc; sel_stall = vecs[i].stall;
      #1;
      chk("imem_req",   i, 32'(imem_req),   32'(vecs[i].req));
      chk("imem_addr",  i, imem_addr,       vecs[i].addr);
      chk("instr_out",  i, instr_out,       vecs[i].instr);
      chk("branch_out", i, 32'(branch_out), 32'(vecs[i].bout));
      chk("branch_ref", i, 32'(branch_ref), 32'(vecs[i].bref));
      chk("pc_out",     i, pc_out,          vecs[i].pcout);
    end

    // streaming with a periodic stall: every word delivered once, in order
    pend = 1'b0; pend_addr = '0; exp_pc = 32'd4; got = 0;
    for (int c = 0; c < 300 && got < 12; c++) begin
      @(negedge clk);
      rst = 1'b0; redirect_en = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
      sel_stall = ((c % 5) < 2);
      imem_rvalid = pend; imem_rdata = d(pend_addr);
      #1;
      if (!sel_stall && instr_out != NOP) begin
        chk("stream_instr", got, instr_out, d(exp_pc));
        chk("stream_pc",    got, pc_out,    exp_pc);
        chk("stream_epoch", got, 32'(branch_out), 32'd0);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      pend = imem_req && imem_gnt;
      pend_addr = imem_addr;
    end
    checks++;
    if (got < 12) begin
      failures++;
      $display("FAIL stream_timeout: delivered %0d expected 12", got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
